// File: rtl/sram_arbiter_pkg.sv
// Shared SRAM arbiter types: FSM state encoding and grant kinds.
// Imported by the arbiter and by any bench that decodes its state.
package sram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD1,
        ST_RD2,
        ST_WR1,
        ST_WR2,
        ST_TURN
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_RD,
        GNT_WR
    } gnt_t;

    // Arbitration only happens when no access is running or one is in its last cycle.
    function automatic logic is_decision(state_t s);
        return (s == ST_IDLE) || (s == ST_RD2) || (s == ST_WR2);
    endfunction

endpackage

// File: rtl/sram_data_io.sv
// SRAM data pad: tristate driver with registered enable/data from the arbiter and a
// capture register that loads the bus on the edge ending the read strobe cycle.
module sram_data_io #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  drive,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  capture,
    output logic [DATA_WIDTH-1:0] rdata,
    inout  wire  [DATA_WIDTH-1:0] pad
);

    assign pad = drive ? wdata : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (capture) begin
            rdata <= pad;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Read-priority arbiter for one async SRAM; 2 clk per access, rd_ack -> rd_valid in 2 clk.
// Requesters hold req until ack; a read burst limit lets a waiting write through.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 18,
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_RD_BURST = 4,
    parameter int TURNAROUND   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ack,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    state_t                state, state_nx;
    gnt_t                  gnt, pend, pend_nx;
    logic [3:0]            burst_cnt, burst_cnt_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_nx;
    logic                  drive_q, drive_nx;
    logic                  ce_n_nx, oe_n_nx, we_n_nx, rd_ack_nx, wr_ack_nx;

    always_comb begin
        gnt          = GNT_NONE;
        state_nx     = ST_IDLE;
        pend_nx      = pend;
        addr_nx      = sram_addr;
        wdata_nx     = wdata_q;
        burst_cnt_nx = burst_cnt;
        ce_n_nx      = 1'b1;
        oe_n_nx      = 1'b1;
        we_n_nx      = 1'b1;
        drive_nx     = 1'b0;
        rd_ack_nx    = 1'b0;
        wr_ack_nx    = 1'b0;

        if (is_decision(state)) begin
            if (rd_req && wr_req) begin
                gnt = (burst_cnt == 4'(MAX_RD_BURST)) ? GNT_WR : GNT_RD;
            end else if (rd_req) begin
                gnt = GNT_RD;
            end else if (wr_req) begin
                gnt = GNT_WR;
            end
        end

        // The grant is latched at the decision edge; TURN only delays its execution.
        case (state)
            ST_RD1:  state_nx = ST_RD2;
            ST_WR1:  state_nx = ST_WR2;
            ST_TURN: state_nx = (pend == GNT_WR) ? ST_WR1 : ST_RD1;
            default: begin
                if (gnt == GNT_RD) begin
                    addr_nx  = rd_addr;
                    pend_nx  = GNT_RD;
                    state_nx = (state == ST_WR2 && TURNAROUND != 0) ? ST_TURN : ST_RD1;
                end else if (gnt == GNT_WR) begin
                    addr_nx  = wr_addr;
                    wdata_nx = wr_data;
                    pend_nx  = GNT_WR;
                    state_nx = (state == ST_RD2 && TURNAROUND != 0) ? ST_TURN : ST_WR1;
                end
            end
        endcase

        if (!wr_req || gnt == GNT_WR) begin
            burst_cnt_nx = '0;
        end else if (gnt == GNT_RD && burst_cnt != 4'(MAX_RD_BURST)) begin
            burst_cnt_nx = burst_cnt + 4'd1;
        end

        // Strobes are decoded from the next state so every pin leaves a flop.
        case (state_nx)
            ST_RD1: begin
                ce_n_nx   = 1'b0;
                oe_n_nx   = 1'b0;
                rd_ack_nx = 1'b1;
            end
            ST_RD2: begin
                ce_n_nx = 1'b0;
                oe_n_nx = 1'b0;
            end
            ST_WR1: begin
                ce_n_nx   = 1'b0;
                we_n_nx   = 1'b0;
                drive_nx  = 1'b1;
                wr_ack_nx = 1'b1;
            end
            ST_WR2: begin
                ce_n_nx  = 1'b0;
                drive_nx = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pend      <= GNT_NONE;
            burst_cnt <= '0;
            sram_addr <= '0;
            wdata_q   <= '0;
            drive_q   <= 1'b0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            rd_ack    <= 1'b0;
            wr_ack    <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            state     <= state_nx;
            pend      <= pend_nx;
            burst_cnt <= burst_cnt_nx;
            sram_addr <= addr_nx;
            wdata_q   <= wdata_nx;
            drive_q   <= drive_nx;
            sram_ce_n <= ce_n_nx;
            sram_oe_n <= oe_n_nx;
            sram_we_n <= we_n_nx;
            rd_ack    <= rd_ack_nx;
            wr_ack    <= wr_ack_nx;
            rd_valid  <= (state == ST_RD2);
        end
    end

    sram_data_io #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_io (
        .clk     (clk),
        .rst_n   (rst_n),
        .drive   (drive_q),
        .wdata   (wdata_q),
        .capture (state == ST_RD2),
        .rdata   (rd_data),
        .pad     (sram_data)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter against a behavioural async SRAM and a memory scoreboard.
`timescale 1ns/1ps
module tb_sram_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          wr_ack, rd_ack, rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;
    logic          sram_ce_n, sram_oe_n, sram_we_n;

    sram_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ack    (rd_ack),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: combinational read, write on the clock edge while WE is low.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    assign sram_data = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : {DW{1'bz}};
    always @(posedge clk) if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_data;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int            cyc = 0;
    int            n_wr_ack = 0, n_rd_ack = 0, n_rd_valid = 0, n_we_low = 0, n_viol = 0;
    int            n_wr_issued = 0, n_rd_issued = 0;
    int            gnt_cyc[$];
    logic [15:0]   gnt_ord = '0;
    int            rack_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model [logic [AW-1:0]];
    logic [AW-1:0] wq_a[$], rq_a[$];
    logic [DW-1:0] wq_d[$];
    int            last_wr_lat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_ack) begin
            n_wr_ack++;
            gnt_cyc.push_back(cyc);
            gnt_ord = {gnt_ord[14:0], 1'b1};
        end
        if (rd_ack) begin
            n_rd_ack++;
            gnt_cyc.push_back(cyc);
            gnt_ord = {gnt_ord[14:0], 1'b0};
            rack_q.push_back(cyc);
        end
        if (!sram_we_n) n_we_low++;
        if (rd_ack && wr_ack) n_viol++;
        if (!sram_oe_n && !sram_we_n) n_viol++;
        if (dut.drive_q && (!sram_oe_n || sram_ce_n)) n_viol++;
        if (!sram_oe_n && sram_data != mem[sram_addr]) n_viol++;
        if (rd_valid) begin
            n_rd_valid++;
            if (rack_q.size() == 0 || exp_q.size() == 0) begin
                check("rd_valid_spurious", 32'(rd_valid), 32'd0);
            end else begin
                check("rd_latency", 32'(cyc - rack_q.pop_front()), 32'd2);
                check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic run_writes(input int max_gap);
        int w;
        while (wq_a.size() > 0) begin
            wr_addr = wq_a[0];
            wr_data = wq_d[0];
            wr_req  = 1'b1;
            w = 0;
            do begin
                @(posedge clk); #1;
                w++;
            end while (!wr_ack && w < 64);
            if (!wr_ack) begin
                check("wr_ack_timeout", 32'(wr_ack), 32'd1);
                wq_a.delete();
                wq_d.delete();
            end else begin
                last_wr_lat = w;
                model[wr_addr] = wr_data;
                n_wr_issued++;
                void'(wq_a.pop_front());
                void'(wq_d.pop_front());
            end
            wr_req = 1'b0;
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
        end
        wr_req = 1'b0;
    endtask

    task automatic run_reads(input int max_gap);
        int w;
        while (rq_a.size() > 0) begin
            rd_addr = rq_a[0];
            rd_req  = 1'b1;
            w = 0;
            do begin
                @(posedge clk); #1;
                w++;
            end while (!rd_ack && w < 64);
            if (!rd_ack) begin
                check("rd_ack_timeout", 32'(rd_ack), 32'd1);
                rq_a.delete();
            end else begin
                exp_q.push_back(model.exists(rd_addr) ? model[rd_addr] : '0);
                n_rd_issued++;
                void'(rq_a.pop_front());
            end
            rd_req = 1'b0;
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
        end
        rd_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, we0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_acks", {30'd0, wr_ack, rd_ack}, 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_drive", 32'(dut.drive_q), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset asserted in WR1 aborts the write
        wr_addr = 18'h00100;
        wr_data = 16'h1111;
        wr_req  = 1'b1;
        @(posedge clk); #1;
        check("t1_in_wr1", 32'(sram_we_n), 32'd0);
        rst_n  = 1'b0;
        wr_req = 1'b0;
        #1;
        check("t1_abort_we_n", 32'(sram_we_n), 32'd1);
        check("t1_abort_ce_n", 32'(sram_ce_n), 32'd1);
        check("t1_abort_wr_ack", 32'(wr_ack), 32'd0);
        check("t1_abort_drive", 32'(dut.drive_q), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t1_no_ack", 32'(n_wr_ack), 32'd0);
        check("t1_mem_untouched", 32'(mem[18'h00100]), 32'd0);
        check("t1_idle_ce_n", 32'(sram_ce_n), 32'd1);

        // Single write
        we0 = n_we_low;
        wq_a.push_back(18'h12345);
        wq_d.push_back(16'hA5A5);
        run_writes(0);
        check("t2_wr_latency", 32'(last_wr_lat), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t2_we_low_cycles", 32'(n_we_low - we0), 32'd1);
        check("t2_mem", 32'(mem[18'h12345]), 32'h0000A5A5);

        // Back-to-back reads
        base = gnt_cyc.size();
        repeat (3) rq_a.push_back(18'h12345);
        run_reads(0);
        repeat (4) @(posedge clk);
        #1;
        check("t3_rd_data", 32'(rd_data), 32'h0000A5A5);
        check("t3_spacing_a", 32'(gnt_cyc[base+1] - gnt_cyc[base]), 32'd2);
        check("t3_spacing_b", 32'(gnt_cyc[base+2] - gnt_cyc[base+1]), 32'd2);

        // Contention: burst limit of 4 reads, then the waiting write
        base = gnt_cyc.size();
        wq_a.push_back(18'h00300); wq_d.push_back(16'hBEEF);
        wq_a.push_back(18'h00301); wq_d.push_back(16'hCAFE);
        repeat (6) rq_a.push_back(18'h12345);
        fork
            run_writes(0);
            run_reads(0);
        join
        repeat (6) @(posedge clk);
        #1;
        check("t4_grant_count", 32'(gnt_cyc.size() - base), 32'd8);
        check("t4_grant_order", 32'(gnt_ord[7:0]), 32'h09);
        check("t4_rr_gap", 32'(gnt_cyc[base+1] - gnt_cyc[base]), 32'd2);
        check("t4_rw_gap", 32'(gnt_cyc[base+4] - gnt_cyc[base+3]), 32'd3);
        check("t4_wr_gap", 32'(gnt_cyc[base+5] - gnt_cyc[base+4]), 32'd3);
        check("t4_rw_gap2", 32'(gnt_cyc[base+7] - gnt_cyc[base+6]), 32'd3);
        check("t4_mem", 32'(mem[18'h00301]), 32'h0000CAFE);

        // Alternating single accesses go through TURN
        base = gnt_cyc.size();
        wq_a.push_back(18'h00040); wq_d.push_back(16'h1234);
        run_writes(0);
        rq_a.push_back(18'h00040);
        run_reads(0);
        wq_a.push_back(18'h00041); wq_d.push_back(16'h5678);
        run_writes(0);
        rq_a.push_back(18'h00041);
        run_reads(0);
        repeat (4) @(posedge clk);
        #1;
        check("t5_wr_gap", 32'(gnt_cyc[base+1] - gnt_cyc[base]), 32'd3);
        check("t5_rw_gap", 32'(gnt_cyc[base+2] - gnt_cyc[base+1]), 32'd3);
        check("t5_wr_gap2", 32'(gnt_cyc[base+3] - gnt_cyc[base+2]), 32'd3);
        check("t5_rd_data", 32'(rd_data), 32'h00005678);

        // Random mixed traffic against the scoreboard
        for (int i = 0; i < 200; i++) begin
            wq_a.push_back(18'($urandom_range(15, 0)));
            wq_d.push_back(16'($urandom));
            rq_a.push_back(18'($urandom_range(15, 0)));
        end
        fork
            run_writes(2);
            run_reads(2);
        join
        repeat (6) @(posedge clk);
        #1;
        check("t6_exp_drained", 32'(exp_q.size()), 32'd0);
        check("wr_ack_count", 32'(n_wr_ack), 32'(n_wr_issued));
        check("rd_ack_count", 32'(n_rd_ack), 32'(n_rd_issued));
        check("rd_valid_count", 32'(n_rd_valid), 32'(n_rd_ack));
        check("we_low_per_write", 32'(n_we_low), 32'(n_wr_ack));
        check("bus_invariants", 32'(n_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
